crypto_out_arbiter: RTL and testbench

//  Shares one 128-bit output stream (out_data_o/out_valid_o/out_ready_i) between the AES and RSA

---
 rtl/crypto_pkg.sv | 24 ++
 rtl/crypto_out_arbiter_if.sv | 28 ++
 rtl/crypto_out_reg.sv | 27 ++
 rtl/crypto_out_arbiter.sv | 125 ++++++++++++
 tb/tb_crypto_out_arbiter.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/crypto_pkg.sv
// Shared types and constants for the crypto output arbiter slice.
package crypto_pkg;

   localparam int unsigned DATA_W        = 128;
   localparam int unsigned BURST_LEN_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_AES = 2'd1,
      GNT_RSA = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_AES = 1'b0,
      SRC_RSA = 1'b1
   } src_e;

   // Payload held in the output stage: beat plus its origin
   typedef struct packed {
      logic [DATA_W-1:0] data;
      src_e              src;
   } beat_t;

endpackage

// File: rtl/crypto_out_arbiter_if.sv
// Signal bundle between the AES/RSA producers, the arbiter and the output sink.
interface crypto_out_arbiter_if;
   import crypto_pkg::*;

   logic              aes_valid_i;
   logic [DATA_W-1:0] aes_data_i;
   logic              aes_ready_o;
   logic              rsa_valid_i;
   logic [DATA_W-1:0] rsa_data_i;
   logic              rsa_ready_o;
   logic [DATA_W-1:0] out_data_o;
   logic              out_src_o;
   logic              out_valid_o;
   logic              out_ready_i;
   logic              busy_o;

   // master: the arbiter itself; slave: producers and sink around it
   modport master (
      input  aes_valid_i, aes_data_i, rsa_valid_i, rsa_data_i, out_ready_i,
      output aes_ready_o, rsa_ready_o, out_data_o, out_src_o, out_valid_o, busy_o
   );

   modport slave (
      output aes_valid_i, aes_data_i, rsa_valid_i, rsa_data_i, out_ready_i,
      input  aes_ready_o, rsa_ready_o, out_data_o, out_src_o, out_valid_o, busy_o
   );

endinterface

// File: rtl/crypto_out_reg.sv
// One-entry valid/ready output register carrying beat data and its source.
module crypto_out_reg
   import crypto_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  beat_t load_beat,
   input  logic  out_ready,
   output logic  out_valid,
   output beat_t out_beat
);

   // Load wins over drain so accept+drain in one cycle keeps the slot full
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_beat  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_beat  <= load_beat;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/crypto_out_arbiter.sv
// Round-robin burst arbiter sharing one registered output stream between AES and RSA.
// Define ARB_RSA_PRIO_EN to make RSA win every contended grant instead of alternating.
module crypto_out_arbiter
   import crypto_pkg::*;
#(
   parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
   input logic                  clk,
   input logic                  rst,
   crypto_out_arbiter_if.master bus
);

   localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

   arb_state_t       state;
   arb_state_t       state_next;
   logic [CNT_W-1:0] beat_cnt;
   src_e             last_src;
   logic             busy_q;

   logic  slot_free_c;
   logic  aes_ready_c;
   logic  rsa_ready_c;
   logic  accept_c;
   logic  burst_last_c;
   beat_t load_beat_c;
   beat_t out_beat;
   logic  out_valid;

   assign slot_free_c  = !out_valid || bus.out_ready_i;
   assign burst_last_c = (beat_cnt == CNT_W'(BURST_LEN - 1));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.aes_valid_i && bus.rsa_valid_i) begin
`ifdef ARB_RSA_PRIO_EN
               state_next = GNT_RSA;
`else
               state_next = (last_src == SRC_AES) ? GNT_RSA : GNT_AES;
`endif
            end else if (bus.aes_valid_i) begin
               state_next = GNT_AES;
            end else if (bus.rsa_valid_i) begin
               state_next = GNT_RSA;
            end
         end
         GNT_AES: begin
            if (!bus.aes_valid_i || (accept_c && burst_last_c)) state_next = IDLE;
         end
         GNT_RSA: begin
            if (!bus.rsa_valid_i || (accept_c && burst_last_c)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic: readies follow the sink combinationally so bursts stream back-to-back
   always_comb begin
      aes_ready_c       = 1'b0;
      rsa_ready_c       = 1'b0;
      load_beat_c       = '0;
      load_beat_c.data  = bus.aes_data_i;
      load_beat_c.src   = SRC_AES;
      case (state)
         GNT_AES: aes_ready_c = bus.aes_valid_i && slot_free_c;
         GNT_RSA: begin
            rsa_ready_c      = bus.rsa_valid_i && slot_free_c;
            load_beat_c.data = bus.rsa_data_i;
            load_beat_c.src  = SRC_RSA;
         end
         default: ;
      endcase
   end

   assign accept_c = aes_ready_c || rsa_ready_c;

   // Beat counter restarts whenever the grant ends, early or at the burst limit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    beat_cnt <= '0;
      else if (state_next == IDLE) beat_cnt <= '0;
      else if (accept_c)           beat_cnt <= beat_cnt + CNT_W'(1);
   end

   // Remember who was granted last for round-robin fairness
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_src <= SRC_RSA;
      end else if (state == IDLE) begin
         if (state_next == GNT_AES)      last_src <= SRC_AES;
         else if (state_next == GNT_RSA) last_src <= SRC_RSA;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy_q <= 1'b0;
      else      busy_q <= (state_next != IDLE);
   end

   crypto_out_reg u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (accept_c),
      .load_beat (load_beat_c),
      .out_ready (bus.out_ready_i),
      .out_valid (out_valid),
      .out_beat  (out_beat)
   );

   assign bus.aes_ready_o = aes_ready_c;
   assign bus.rsa_ready_o = rsa_ready_c;
   assign bus.out_valid_o = out_valid;
   assign bus.out_data_o  = out_beat.data;
   assign bus.out_src_o   = 1'(out_beat.src);
   assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_crypto_out_arbiter.sv
// Directed, table-driven bench for crypto_out_arbiter (default round-robin build).
module tb_crypto_out_arbiter;
   import crypto_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   crypto_out_arbiter_if bus ();

   crypto_out_arbiter #(.BURST_LEN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       av;
      logic [7:0] ad;
      logic       rv;
      logic [7:0] rd;
      logic       ordy;
      logic       e_ar;
      logic       e_rr;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_os;
      logic       e_busy;
   } vec_t;

   vec_t tbl [36];

   function automatic vec_t mk(logic av, logic [7:0] ad, logic rv, logic [7:0] rd, logic ordy,
                               logic ar, logic rr, logic ov, logic [7:0] od, logic os, logic busy);
      vec_t v;
      v.av = av; v.ad = ad; v.rv = rv; v.rd = rd; v.ordy = ordy;
      v.e_ar = ar; v.e_rr = rr; v.e_ov = ov; v.e_od = od; v.e_os = os; v.e_busy = busy;
      return v;
   endfunction

   task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(logic av, logic [7:0] ad, logic rv, logic [7:0] rd, logic ordy);
      bus.aes_valid_i = av;
      bus.aes_data_i  = {16{ad}};
      bus.rsa_valid_i = rv;
      bus.rsa_data_i  = {16{rd}};
      bus.out_ready_i = ordy;
   endtask

   initial begin
      // AES-only bursts with a bubble (rows 0-9)
      tbl[0]  = mk(1, 8'hA0, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0, 0);
      tbl[1]  = mk(1, 8'hA1, 0, 8'h00, 1,  1, 0, 0, 8'h00, 0, 1);
      tbl[2]  = mk(1, 8'hA2, 0, 8'h00, 1,  1, 0, 1, 8'hA1, 0, 1);
      tbl[3]  = mk(1, 8'hA3, 0, 8'h00, 1,  1, 0, 1, 8'hA2, 0, 1);
      tbl[4]  = mk(1, 8'hA4, 0, 8'h00, 1,  1, 0, 1, 8'hA3, 0, 1);
      tbl[5]  = mk(1, 8'hA5, 0, 8'h00, 1,  0, 0, 1, 8'hA4, 0, 0);
      tbl[6]  = mk(1, 8'hB1, 0, 8'h00, 1,  1, 0, 0, 8'hA4, 0, 1);
      tbl[7]  = mk(1, 8'hB2, 0, 8'h00, 1,  1, 0, 1, 8'hB1, 0, 1);
      tbl[8]  = mk(1, 8'hB3, 0, 8'h00, 1,  1, 0, 1, 8'hB2, 0, 1);
      tbl[9]  = mk(1, 8'hB4, 0, 8'h00, 1,  1, 0, 1, 8'hB3, 0, 1);
      // Both valid: RSA burst (last was AES), then AES burst with a 5-cycle stall
      tbl[10] = mk(1, 8'hC1, 1, 8'hD1, 1,  0, 0, 1, 8'hB4, 0, 0);
      tbl[11] = mk(1, 8'hC2, 1, 8'hD2, 1,  0, 1, 0, 8'hB4, 0, 1);
      tbl[12] = mk(1, 8'hC3, 1, 8'hD3, 1,  0, 1, 1, 8'hD2, 1, 1);
      tbl[13] = mk(1, 8'hC4, 1, 8'hD4, 1,  0, 1, 1, 8'hD3, 1, 1);
      tbl[14] = mk(1, 8'hC5, 1, 8'hD5, 1,  0, 1, 1, 8'hD4, 1, 1);
      tbl[15] = mk(1, 8'hC6, 1, 8'hD6, 1,  0, 0, 1, 8'hD5, 1, 0);
      tbl[16] = mk(1, 8'hC7, 1, 8'hD7, 1,  1, 0, 0, 8'hD5, 1, 1);
      tbl[17] = mk(1, 8'hC8, 1, 8'hD8, 1,  1, 0, 1, 8'hC7, 0, 1);
      for (int i = 18; i <= 22; i++)
         tbl[i] = mk(1, 8'hC9, 1, 8'hD9, 0,  0, 0, 1, 8'hC8, 0, 1);
      tbl[23] = mk(1, 8'hC9, 1, 8'hD9, 1,  1, 0, 1, 8'hC8, 0, 1);
      tbl[24] = mk(1, 8'hCA, 1, 8'hDA, 1,  1, 0, 1, 8'hC9, 0, 1);
      // RSA drops after 2 beats, pending AES then gets a full burst
      tbl[25] = mk(1, 8'hE0, 1, 8'hF0, 1,  0, 0, 1, 8'hCA, 0, 0);
      tbl[26] = mk(1, 8'hE1, 1, 8'hF1, 1,  0, 1, 0, 8'hCA, 0, 1);
      tbl[27] = mk(1, 8'hE2, 1, 8'hF2, 1,  0, 1, 1, 8'hF1, 1, 1);
      tbl[28] = mk(1, 8'hE3, 0, 8'h00, 1,  0, 0, 1, 8'hF2, 1, 1);
      tbl[29] = mk(1, 8'hE4, 0, 8'h00, 1,  0, 0, 0, 8'hF2, 1, 0);
      tbl[30] = mk(1, 8'hE5, 0, 8'h00, 1,  1, 0, 0, 8'hF2, 1, 1);
      tbl[31] = mk(1, 8'hE6, 0, 8'h00, 1,  1, 0, 1, 8'hE5, 0, 1);
      tbl[32] = mk(1, 8'hE7, 0, 8'h00, 1,  1, 0, 1, 8'hE6, 0, 1);
      tbl[33] = mk(1, 8'hE8, 0, 8'h00, 1,  1, 0, 1, 8'hE7, 0, 1);
      tbl[34] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'hE8, 0, 0);
      tbl[35] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'hE8, 0, 0);

      // Reset held, then idle with all inputs low
      drive(0, 8'h00, 0, 8'h00, 0);
      repeat (3) @(negedge clk);
      check("rst_held_ov", bus.out_valid_o, 0);
      check("rst_held_busy", bus.busy_o, 0);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         check($sformatf("idle%0d_ov", i), bus.out_valid_o, 0);
         check($sformatf("idle%0d_od", i), bus.out_data_o, 0);
         check($sformatf("idle%0d_busy", i), bus.busy_o, 0);
         check($sformatf("idle%0d_rdy", i), {bus.aes_ready_o, bus.rsa_ready_o, bus.out_src_o}, 0);
      end

      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         drive(tbl[i].av, tbl[i].ad, tbl[i].rv, tbl[i].rd, tbl[i].ordy);
         #1;
         check($sformatf("v%0d_aes_ready", i), bus.aes_ready_o, tbl[i].e_ar);
         check($sformatf("v%0d_rsa_ready", i), bus.rsa_ready_o, tbl[i].e_rr);
         check($sformatf("v%0d_out_valid", i), bus.out_valid_o, tbl[i].e_ov);
         check($sformatf("v%0d_out_data", i), bus.out_data_o, {16{tbl[i].e_od}});
         check($sformatf("v%0d_out_src", i), bus.out_src_o, tbl[i].e_os);
         check($sformatf("v%0d_busy", i), bus.busy_o, tbl[i].e_busy);
      end

      // Async reset mid-burst with a beat held, then AES wins the first contended grant
      @(negedge clk);
      drive(1, 8'h55, 0, 8'h00, 1);
      @(negedge clk);
      @(negedge clk); #1;
      check("t6_pre_ov", bus.out_valid_o, 1);
      check("t6_pre_od", bus.out_data_o, {16{8'h55}});
      #2 rst = 1'b0;
      #1;
      check("t6_rst_ov", bus.out_valid_o, 0);
      check("t6_rst_od", bus.out_data_o, 0);
      check("t6_rst_busy", bus.busy_o, 0);
      check("t6_rst_aes_ready", bus.aes_ready_o, 0);
      @(negedge clk);
      rst = 1'b1;
      drive(1, 8'h66, 1, 8'h77, 1);
      @(negedge clk); #1;
      check("t6_gnt_aes_ready", bus.aes_ready_o, 1);
      check("t6_gnt_rsa_ready", bus.rsa_ready_o, 0);
      check("t6_gnt_busy", bus.busy_o, 1);
      @(negedge clk); #1;
      check("t6_out_valid", bus.out_valid_o, 1);
      check("t6_out_data", bus.out_data_o, {16{8'h66}});
      check("t6_out_src", bus.out_src_o, 0);

      drive(0, 8'h00, 0, 8'h00, 1);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
